// File: rtl/fifo_pkg.sv
// Shared packing and state definitions for the 80-bit packet FIFO, used by
// the write side, the read-side serializer and the bench.
package fifo_pkg;

  localparam int PKT_BYTES = 10;
  localparam int BYTE_W    = 8;
  localparam int PKT_W     = PKT_BYTES * BYTE_W;

  // Byte j of a packet word lives at word[j*BYTE_W +: BYTE_W].
  typedef logic [PKT_W-1:0] pkt_word_t;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    WAIT,
    SEND
  } ser_state_t;

endpackage

// File: rtl/fifo_pkt_serializer.sv
// Read-side FIFO consumer: pops one packet word at a time and streams it out
// byte 0 first over a valid/ready interface with sop/eop markers.
module fifo_pkt_serializer #(
  parameter int PKT_BYTES  = fifo_pkg::PKT_BYTES,
  parameter int BYTE_W     = fifo_pkg::BYTE_W,
  parameter int RD_LATENCY = 1,
  parameter int CNT_W      = 16
) (
  input  logic                        read_clk,
  input  logic                        rst,
  input  logic                        drain_en,
  input  logic                        fifo_empty,
  input  logic [PKT_BYTES*BYTE_W-1:0] fifo_data_out,
  output logic                        fifo_rd_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BYTE_W-1:0]           out_data,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [CNT_W-1:0]            pkt_count,
  output logic                        busy
);
  import fifo_pkg::*;

  localparam int WORD_W = PKT_BYTES * BYTE_W;
  localparam int IDX_W  = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

  ser_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic [WORD_W-1:0] word;
  logic [BYTE_W-1:0] next_byte;
  logic              handshake;
  logic              can_pop;

  always_comb begin
    idx_nxt   = idx + 1'b1;
    next_byte = word[idx_nxt*BYTE_W +: BYTE_W];
    handshake = out_valid && out_ready;
    can_pop   = drain_en && !fifo_empty;
  end

  // Every output is a register written alongside the state, so out_ready
  // never reaches fifo_rd_en combinationally.
  always_ff @(posedge read_clk) begin
    // NOTE: reset is synchronous, so it sits inside the clocked block rather
    // than in the sensitivity list; the word register is a single flop bank,
    // cheap to clear, so it is reset along with everything else.
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      lat_cnt    <= '0;
      word       <= '0;
      pkt_count  <= '0;
      fifo_rd_en <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here: every branch reads
      // the pre-edge values of idx, word and state, never a value updated
      // earlier in the same edge.
      case (state)
        IDLE: begin
          if (can_pop) begin
            state      <= POP;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        POP: begin
          fifo_rd_en <= 1'b0;
          lat_cnt    <= LAT_LOAD;
          state      <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            word      <= fifo_data_out;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= fifo_data_out[BYTE_W-1:0];
            out_sop   <= 1'b1;
            out_eop   <= (LAST_IDX == '0);
            state     <= SEND;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        SEND: begin
          if (handshake) begin
            if (idx == LAST_IDX) begin
              pkt_count <= pkt_count + 1'b1;
              out_valid <= 1'b0;
              out_sop   <= 1'b0;
              out_eop   <= 1'b0;
              if (can_pop) begin
                state      <= POP;
                fifo_rd_en <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              idx      <= idx_nxt;
              out_data <= next_byte;
              out_sop  <= 1'b0;
              out_eop  <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
